// File: rtl/multi_channel_pulse_counter_pkg.sv
// Shared types and helpers for the multi-channel pulse counter.
// Pure definitions: no latency or backpressure of their own.
package pulse_counter_pkg;

  localparam int LANE_PITCH    = 16;
  localparam int LANE_BUS_BITS = 1024;

  typedef enum logic {
    MODE_EDGE  = 1'b0,
    MODE_LEVEL = 1'b1
  } mode_e;

  typedef logic [0:0] emit_state_t;
  localparam emit_state_t ST_IDLE = 1'b0;
  localparam emit_state_t ST_SEND = 1'b1;

  // Pulls one 16-bit lane out of a zero-extended stream word.
  function automatic logic [LANE_PITCH-1:0] lane_extract(
    input logic [LANE_BUS_BITS-1:0] bus,
    input int unsigned              idx
  );
    return LANE_PITCH'(bus >> (idx * LANE_PITCH));
  endfunction

endpackage

// File: rtl/multi_channel_pulse_counter_hysteresis_channel.sv
// One channel: hysteresis comparator plus saturating event counter, 1 cycle from valid sample to count.
// count_total/sat_total include the current cycle's event so a gate end captures it; no backpressure.
module hysteresis_channel
  import pulse_counter_pkg::*;
#(
  parameter int ADC_WIDTH   = 14,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        gate_end,
  input  logic                        sample_vld,
  input  logic signed [ADC_WIDTH-1:0] sample,
  input  logic signed [ADC_WIDTH-1:0] high_threshold,
  input  logic signed [ADC_WIDTH-1:0] low_threshold,
  input  mode_e                       mode,
  output logic                        pulse,
  output logic [COUNT_WIDTH-1:0]      count_total,
  output logic                        sat_total
);

  logic                   state_q;
  logic                   state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   sat_q;
  logic                   hit;

  always_comb begin
    state_d = state_q;
    if (sample_vld) begin
      // High test first so inverted thresholds resolve to HIGH.
      if (sample >= high_threshold) begin
        state_d = 1'b1;
      end else if (sample <= low_threshold) begin
        state_d = 1'b0;
      end
    end

    hit = 1'b0;
    if (sample_vld) begin
      hit = (mode == MODE_LEVEL) ? state_d : (state_d && !state_q);
    end

    count_total = count_q;
    sat_total   = sat_q;
    if (hit) begin
      if (&count_q) begin
        sat_total = 1'b1;
      end else begin
        count_total = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (!enable) begin
      state_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gate_end) begin
        count_q <= '0;
        sat_q   <= 1'b0;
      end else begin
        count_q <= count_total;
        sat_q   <= sat_total;
      end
    end
  end

  assign pulse = state_q;

endmodule

// File: rtl/multi_channel_pulse_counter.sv
// Gated multi-channel pulse counter: 2 cycles sample-to-count, gate end to first word 1 cycle, one word per channel.
// Output word holds while tready is low; a gate end that finds the emitter busy drops its results and sets overrun.
module multi_channel_pulse_counter
  import pulse_counter_pkg::*;
#(
  parameter int N_CH             = 2,
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32,
  parameter int GATE_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IN_tdata,
  input  logic                        S_AXIS_IN_tvalid,
  input  logic signed [ADC_WIDTH-1:0] high_threshold,
  input  logic signed [ADC_WIDTH-1:0] low_threshold,
  input  logic [GATE_WIDTH-1:0]       gate_len,
  input  logic                        mode,
  input  logic                        enable,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  output logic                        M_AXIS_OUT_tlast,
  input  logic                        M_AXIS_OUT_tready,
  output logic [N_CH-1:0]             sat_flags,
  output logic                        overrun,
  output logic [GATE_WIDTH-1:0]       gate_timer,
  output logic [N_CH-1:0]             pulse
);

  localparam int              CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic                        in_vld;
  logic [AXIS_TDATA_WIDTH-1:0] in_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld <= 1'b0;
      in_dat <= '0;
    end else begin
      in_vld <= S_AXIS_IN_tvalid;
      if (S_AXIS_IN_tvalid) begin
        in_dat <= S_AXIS_IN_tdata;
      end
    end
  end

  // Gate length and mode are sampled only between windows so a window never mixes settings.
  logic [GATE_WIDTH-1:0] gate_len_q;
  mode_e                 mode_q;
  logic                  gate_run;
  logic                  gate_end;

  assign gate_run = enable && (gate_len_q != '0);
  assign gate_end = gate_run && (gate_timer == gate_len_q - GATE_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_timer <= '0;
      gate_len_q <= '0;
      mode_q     <= MODE_EDGE;
    end else begin
      if (!enable || gate_end || (gate_len_q == '0)) begin
        gate_len_q <= gate_len;
        mode_q     <= mode_e'(mode);
      end
      if (!gate_run || gate_end) begin
        gate_timer <= '0;
      end else begin
        gate_timer <= gate_timer + GATE_WIDTH'(1);
      end
    end
  end

  logic [N_CH-1:0][COUNT_WIDTH-1:0] ch_count;
  logic [N_CH-1:0]                  ch_sat;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [ADC_WIDTH-1:0] sample;

    assign sample = ADC_WIDTH'(lane_extract(LANE_BUS_BITS'(in_dat), k));

    hysteresis_channel #(
      .ADC_WIDTH  (ADC_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .gate_end      (gate_end),
      .sample_vld    (in_vld),
      .sample        (sample),
      .high_threshold(high_threshold),
      .low_threshold (low_threshold),
      .mode          (mode_q),
      .pulse         (pulse[k]),
      .count_total   (ch_count[k]),
      .sat_total     (ch_sat[k])
    );
  end

  logic [N_CH-1:0][COUNT_WIDTH-1:0] result_q;
  emit_state_t                      state_q;
  logic [CH_W-1:0]                  ch_q;
  logic                             beat;

  assign beat = (state_q == ST_SEND) && M_AXIS_OUT_tready;

  // The capture edge also launches the frame, giving the single cycle from gate end to tvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      result_q  <= '0;
      sat_flags <= '0;
      overrun   <= 1'b0;
    end else begin
      if (gate_end) begin
        if (state_q == ST_IDLE) begin
          result_q  <= ch_count;
          sat_flags <= ch_sat;
          state_q   <= ST_SEND;
          ch_q      <= '0;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (beat) begin
        if (ch_q == LAST_CH) begin
          state_q <= ST_IDLE;
          ch_q    <= '0;
        end else begin
          ch_q <= ch_q + CH_W'(1);
        end
      end
    end
  end

  assign M_AXIS_OUT_tvalid = (state_q == ST_SEND);
  assign M_AXIS_OUT_tlast  = M_AXIS_OUT_tvalid && (ch_q == LAST_CH);
  assign M_AXIS_OUT_tdata  = M_AXIS_OUT_tvalid ? AXIS_TDATA_WIDTH'(result_q[ch_q]) : '0;

endmodule

// File: tb/tb_multi_channel_pulse_counter.sv
// Directed bench: square waves, hysteresis, saturation (narrow-counter instance), backpressure, overrun, reset.
module tb_multi_channel_pulse_counter;

  localparam int K_SQ   = 0;
  localparam int K_ALT  = 1;
  localparam int K_HI   = 2;
  localparam int K_ZERO = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        s_tdata;
  logic               s_tvalid;
  logic signed [13:0] hi_th;
  logic signed [13:0] lo_th;
  logic [31:0]        gate_len;
  logic               mode;
  logic               enable;
  logic               m_tready;

  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [1:0]  sat_flags;
  logic        overrun;
  logic [31:0] gate_timer;
  logic [1:0]  pulse;

  logic [31:0] z_tdata;
  logic        z_tvalid;
  logic        z_tlast;
  logic [1:0]  z_sat_flags;
  logic        z_overrun;
  logic [31:0] z_gate_timer;
  logic [1:0]  z_pulse;

  always #5 clk = ~clk;

  multi_channel_pulse_counter dut (
    .clk(clk), .rst(rst),
    .S_AXIS_IN_tdata(s_tdata), .S_AXIS_IN_tvalid(s_tvalid),
    .high_threshold(hi_th), .low_threshold(lo_th),
    .gate_len(gate_len), .mode(mode), .enable(enable),
    .M_AXIS_OUT_tdata(m_tdata), .M_AXIS_OUT_tvalid(m_tvalid),
    .M_AXIS_OUT_tlast(m_tlast), .M_AXIS_OUT_tready(m_tready),
    .sat_flags(sat_flags), .overrun(overrun),
    .gate_timer(gate_timer), .pulse(pulse)
  );

  multi_channel_pulse_counter #(.COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst),
    .S_AXIS_IN_tdata(s_tdata), .S_AXIS_IN_tvalid(s_tvalid),
    .high_threshold(hi_th), .low_threshold(lo_th),
    .gate_len(gate_len), .mode(mode), .enable(enable),
    .M_AXIS_OUT_tdata(z_tdata), .M_AXIS_OUT_tvalid(z_tvalid),
    .M_AXIS_OUT_tlast(z_tlast), .M_AXIS_OUT_tready(m_tready),
    .sat_flags(z_sat_flags), .overrun(z_overrun),
    .gate_timer(z_gate_timer), .pulse(z_pulse)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Per-channel stimulus generator, one new sample word per cycle.
  int cyc = 0;
  int kind0 = K_SQ;
  int kind1 = K_SQ;
  bit vld_alt = 1'b0;

  function automatic logic [13:0] sample_of(input int kind, input int c);
    case (kind)
      K_SQ:    return (((c / 10) % 2) == 0) ? 14'd8000 : 14'd0;
      K_ALT:   return ((c % 2) == 0) ? 14'd3000 : 14'd5000;
      K_HI:    return 14'd8000;
      default: return 14'd0;
    endcase
  endfunction

  initial begin
    s_tdata  = '0;
    s_tvalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      s_tdata  = {2'b00, sample_of(kind1, cyc), 2'b00, sample_of(kind0, cyc)};
      s_tvalid = vld_alt ? cyc[0] : 1'b1;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  sf;
    logic [31:0] zd;
    logic [1:0]  zsf;
  } word_t;

  word_t q[$];
  word_t mon_w;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      mon_w.d   = m_tdata;
      mon_w.l   = m_tlast;
      mon_w.sf  = sat_flags;
      mon_w.zd  = z_tdata;
      mon_w.zsf = z_sat_flags;
      q.push_back(mon_w);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_frame(output word_t f0, output word_t f1);
    int n = 0;
    while (q.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() < 2) begin
      check("frame_timeout", 32'(q.size()), 32'd2);
      f0 = '{default: '0};
      f1 = '{default: '0};
    end else begin
      f0 = q.pop_front();
      f1 = q.pop_front();
    end
  endtask

  task automatic wait_tvalid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!m_tvalid && n < 250) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(m_tvalid), 32'd1);
  endtask

  task automatic start_phase(input int m, input int k0, input int k1, input bit va);
    step();
    enable = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("dis_timer", gate_timer, 32'd0);
    check("dis_pulse", 32'(pulse), 32'd0);
    step();
    mode    = m[0];
    kind0   = k0;
    kind1   = k1;
    vld_alt = va;
    q.delete();
    step();
    enable = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  word_t f0, f1;
  int    n;
  int    changed;

  initial begin
    enable   = 1'b0;
    mode     = 1'b0;
    gate_len = 32'd100;
    hi_th    = 14'sd6000;
    lo_th    = 14'sd2000;
    m_tready = 1'b1;
    rst      = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_sat", 32'(sat_flags), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timer", gate_timer, 32'd0);
    check("rst_pulse", 32'(pulse), 32'd0);
    step();
    rst = 1'b0;

    // Square wave, rising-edge count: 5 edges per 100-cycle window.
    start_phase(0, K_SQ, K_SQ, 1'b0);
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("edge_ch0", f0.d, 32'd5);
    check("edge_ch1", f1.d, 32'd5);
    check("edge_w0_last", 32'(f0.l), 32'd0);
    check("edge_w1_last", 32'(f1.l), 32'd1);

    n = 0;
    @(negedge clk);
    while (gate_timer != 32'd99 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("gate_end_seen", gate_timer, 32'd99);
    check("gate_end_idle", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("lat_tvalid", 32'(m_tvalid), 32'd1);
    check("lat_w0_last", 32'(m_tlast), 32'd0);
    check("timer_wrap", gate_timer, 32'd0);
    @(negedge clk);
    check("w1_tvalid", 32'(m_tvalid), 32'd1);
    check("w1_tlast", 32'(m_tlast), 32'd1);
    @(negedge clk);
    check("frame_len", 32'(m_tvalid), 32'd0);

    // Same wave, level count: 50 high samples per window.
    start_phase(1, K_SQ, K_SQ, 1'b0);
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("level_ch0", f0.d, 32'd50);
    check("level_ch1", f1.d, 32'd50);
    check("level_sat", 32'(f1.sf), 32'd0);

    // Samples between thresholds never leave LOW.
    start_phase(0, K_ALT, K_SQ, 1'b0);
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("hyst_ch0", f0.d, 32'd0);
    check("hyst_ch1", f1.d, 32'd5);
    @(negedge clk);
    check("hyst_pulse0", 32'(pulse[0]), 32'd0);

    // Constant high, level count: 100 on the wide counter, 4-bit counter pins at 15.
    start_phase(1, K_HI, K_HI, 1'b0);
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("hi_ch0", f0.d, 32'd100);
    check("hi_ch1", f1.d, 32'd100);
    check("hi_sat", 32'(f1.sf), 32'd0);
    check("sat_ch0", f0.zd, 32'd15);
    check("sat_ch1", f1.zd, 32'd15);
    check("sat_flags", 32'(f1.zsf), 32'd3);
    check("hi_pulse", 32'(pulse), 32'd3);
    step();
    kind0 = K_ZERO;
    kind1 = K_ZERO;
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("zero_ch0", f0.d, 32'd0);
    check("sat_clr_ch0", f0.zd, 32'd0);
    check("sat_clr_ch1", f1.zd, 32'd0);
    check("sat_clr_flags", 32'(f1.zsf), 32'd0);

    // Every other sample valid: only 50 count in level mode.
    start_phase(1, K_HI, K_HI, 1'b1);
    get_frame(f0, f1);
    get_frame(f0, f1);
    check("halfvld_ch0", f0.d, 32'd50);
    check("halfvld_ch1", f1.d, 32'd50);

    // Backpressure across two gate ends; the second window's zero counts must be dropped.
    start_phase(0, K_SQ, K_SQ, 1'b0);
    get_frame(f0, f1);
    step();
    m_tready = 1'b0;
    wait_tvalid("bp_w0_vld");
    check("bp_w0_dat", m_tdata, 32'd5);
    check("bp_w0_last", 32'(m_tlast), 32'd0);
    step();
    kind0   = K_ZERO;
    kind1   = K_ZERO;
    changed = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd5 || m_tlast !== 1'b0) changed++;
    end
    check("ovr_before_2nd", 32'(overrun), 32'd0);
    repeat (90) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd5 || m_tlast !== 1'b0) changed++;
    end
    check("bp_w0_held", 32'(changed), 32'd0);
    check("ovr_after_2nd", 32'(overrun), 32'd1);
    step();
    q.delete();
    m_tready = 1'b1;
    get_frame(f0, f1);
    check("bp_ch0", f0.d, 32'd5);
    check("bp_ch1", f1.d, 32'd5);
    check("bp_w1_last", 32'(f1.l), 32'd1);

    // Reset in the middle of a held frame.
    step();
    m_tready = 1'b0;
    wait_tvalid("mid_vld");
    check("ovr_sticky", 32'(overrun), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tdata", m_tdata, 32'd0);
    check("mid_rst_tlast", 32'(m_tlast), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_sat", 32'(sat_flags), 32'd0);
    check("mid_rst_timer", gate_timer, 32'd0);
    check("mid_rst_pulse", 32'(pulse), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
